// File: rtl/score_keeper_pkg.sv
// Shared scoring types and constants, also used by the text renderer.
// Holds the game-mode encoding, the scoring FSM states and the default point values.
package score_keeper_pkg;

    typedef enum logic [1:0] {
        GAME_MODE_READY   = 2'd0,
        GAME_MODE_PLAYING = 2'd1,
        GAME_MODE_FAIL    = 2'd2,
        GAME_MODE_LOADING = 2'd3
    } game_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } score_state_t;

    typedef struct packed {
        logic pellet;
        logic power;
        logic ghost;
        logic fright_end;
    } score_evt_t;

    localparam int SCORE_W            = 16;
    localparam int SCORE_MAX_DEF      = 9999;
    localparam int EXTRA_LIFE_AT_DEF  = 5000;
    localparam int PTS_PELLET_DEF     = 10;
    localparam int PTS_POWER_DEF      = 50;
    localparam int PTS_GHOST_BASE_DEF = 200;
    localparam logic [1:0] COMBO_MAX  = 2'd3;

    // Ghost value doubles per combo step; 17 bits so the sum with score cannot wrap.
    function automatic logic [SCORE_W:0] ghost_pts(input logic [SCORE_W:0] base,
                                                   input logic [1:0]       combo);
        return base << combo;
    endfunction

endpackage

// File: rtl/score_keeper_fsm.sv
// Game-phase tracker for the score keeper: decides when events score and when
// the per-game state is cleared.
module score_fsm
    import score_keeper_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  game_mode_t mode,
    output logic       scoring_en,
    output logic       clear
);

    score_state_t state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (mode == GAME_MODE_READY) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (mode == GAME_MODE_PLAYING) state_nxt = ST_PLAY;
                ST_PLAY: begin
                    if (mode == GAME_MODE_FAIL)         state_nxt = ST_OVER;
                    else if (mode == GAME_MODE_LOADING) state_nxt = ST_IDLE;
                end
                ST_OVER: state_nxt = ST_OVER;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Clear wins over scoring so a READY cycle never leaks points into the new game.
    always_comb begin
        clear      = (mode == GAME_MODE_READY);
        scoring_en = (state == ST_PLAY) && !clear;
    end

endmodule

// File: rtl/score_keeper.sv
// Scoring datapath: per-cycle increment, ghost combo, saturating score,
// session high score and the once-per-game extra-life pulse.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int SCORE_MAX      = SCORE_MAX_DEF,
    parameter int EXTRA_LIFE_AT  = EXTRA_LIFE_AT_DEF,
    parameter int PTS_PELLET     = PTS_PELLET_DEF,
    parameter int PTS_POWER      = PTS_POWER_DEF,
    parameter int PTS_GHOST_BASE = PTS_GHOST_BASE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  game_mode_t         MODE,
    input  logic               pellet_eaten,
    input  logic               power_eaten,
    input  logic               ghost_eaten,
    input  logic               fright_end,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high,
    output logic               extra_life
);

    localparam logic [SCORE_W:0] MAX_W   = (SCORE_W+1)'(SCORE_MAX);
    localparam logic [SCORE_W:0] LIFE_W  = (SCORE_W+1)'(EXTRA_LIFE_AT);
    localparam logic [SCORE_W:0] PEL_W   = (SCORE_W+1)'(PTS_PELLET);
    localparam logic [SCORE_W:0] POW_W   = (SCORE_W+1)'(PTS_POWER);
    localparam logic [SCORE_W:0] GHOST_W = (SCORE_W+1)'(PTS_GHOST_BASE);

    score_evt_t         evt;
    logic               scoring_en, clear;
    logic [1:0]         combo, combo_next;
    logic               life_given, life_hit;
    logic [SCORE_W:0]   inc, sum;
    logic [SCORE_W-1:0] score_next;

    assign evt = '{pellet: pellet_eaten, power: power_eaten,
                   ghost: ghost_eaten, fright_end: fright_end};

    score_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .mode       (MODE),
        .scoring_en (scoring_en),
        .clear      (clear)
    );

    always_comb begin
        inc = '0;
        if (evt.pellet) inc = inc + PEL_W;
        if (evt.power)  inc = inc + POW_W;
        if (evt.ghost)  inc = inc + ghost_pts(GHOST_W, combo);

        sum        = {1'b0, score} + inc;
        score_next = (sum > MAX_W) ? MAX_W[SCORE_W-1:0] : sum[SCORE_W-1:0];

        // A combo reset in the same cycle as a ghost still scores that ghost at the old combo.
        combo_next = combo;
        if (evt.power || evt.fright_end)         combo_next = 2'd0;
        else if (evt.ghost && combo != COMBO_MAX) combo_next = combo + 2'd1;

        life_hit = ({1'b0, score} < LIFE_W) && ({1'b0, score_next} >= LIFE_W) && !life_given;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score      <= '0;
            high_score <= '0;
            new_high   <= 1'b0;
            extra_life <= 1'b0;
            combo      <= 2'd0;
            life_given <= 1'b0;
        end else if (clear) begin
            score      <= '0;
            new_high   <= 1'b0;
            extra_life <= 1'b0;
            combo      <= 2'd0;
            life_given <= 1'b0;
        end else begin
            extra_life <= 1'b0;
            if (scoring_en) begin
                score <= score_next;
                combo <= combo_next;
                if (score_next > high_score) begin
                    high_score <= score_next;
                    new_high   <= 1'b1;
                end
                if (life_hit) begin
                    extra_life <= 1'b1;
                    life_given <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a reference model pushes the expected outputs
// for each cycle onto a queue, which is popped and compared after the edge.
module tb_score_keeper;
    import score_keeper_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    game_mode_t  MODE = GAME_MODE_READY;
    logic        pellet_eaten = 1'b0, power_eaten = 1'b0, ghost_eaten = 1'b0, fright_end = 1'b0;
    logic [15:0] score, high_score;
    logic        new_high, extra_life;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int score;
        int high;
        int nh;
        int el;
    } exp_t;
    exp_t sb[$];

    // reference model state (0 idle, 1 play, 2 over)
    int m_state = 0, m_score = 0, m_high = 0, m_nh = 0, m_el = 0, m_combo = 0, m_lg = 0;

    score_keeper dut (
        .clk          (clk),
        .rst          (rst),
        .MODE         (MODE),
        .pellet_eaten (pellet_eaten),
        .power_eaten  (power_eaten),
        .ghost_eaten  (ghost_eaten),
        .fright_end   (fright_end),
        .score        (score),
        .high_score   (high_score),
        .new_high     (new_high),
        .extra_life   (extra_life)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input game_mode_t m, input bit p, input bit w, input bit g, input bit f);
        int inc, nxt;
        m_el = 0;
        if (m == GAME_MODE_READY) begin
            m_score = 0; m_combo = 0; m_nh = 0; m_lg = 0;
        end else if (m_state == 1) begin
            inc = (p ? 10 : 0) + (w ? 50 : 0) + (g ? (200 << m_combo) : 0);
            nxt = (m_score + inc > 9999) ? 9999 : m_score + inc;
            if (m_score < 5000 && nxt >= 5000 && m_lg == 0) begin
                m_el = 1; m_lg = 1;
            end
            if (nxt > m_high) begin
                m_high = nxt; m_nh = 1;
            end
            m_score = nxt;
            if (w || f)               m_combo = 0;
            else if (g && m_combo < 3) m_combo = m_combo + 1;
        end
        if (m == GAME_MODE_READY)                         m_state = 0;
        else if (m_state == 0 && m == GAME_MODE_PLAYING)  m_state = 1;
        else if (m_state == 1 && m == GAME_MODE_FAIL)     m_state = 2;
        else if (m_state == 1 && m == GAME_MODE_LOADING)  m_state = 0;
        sb.push_back('{score: m_score, high: m_high, nh: m_nh, el: m_el});
    endtask

    task automatic step(input game_mode_t m, input bit p, input bit w, input bit g, input bit f);
        exp_t e;
        MODE = m; pellet_eaten = p; power_eaten = w; ghost_eaten = g; fright_end = f;
        model(m, p, w, g, f);
        @(posedge clk);
        #1;
        pellet_eaten = 0; power_eaten = 0; ghost_eaten = 0; fright_end = 0;
        e = sb.pop_front();
        chk("sb_score", int'(score), e.score);
        chk("sb_high", int'(high_score), e.high);
        chk("sb_new_high", int'(new_high), e.nh);
        chk("sb_extra_life", int'(extra_life), e.el);
    endtask

    initial begin
        #1;
        chk("rst_score", int'(score), 0);
        chk("rst_high", int'(high_score), 0);
        chk("rst_new_high", int'(new_high), 0);
        chk("rst_extra_life", int'(extra_life), 0);
        @(negedge clk);
        rst = 0;

        // game 1
        step(GAME_MODE_READY, 0, 0, 0, 0);
        step(GAME_MODE_PLAYING, 1, 0, 0, 0);
        chk("entry_ignored", int'(score), 0);
        repeat (3) step(GAME_MODE_PLAYING, 1, 0, 0, 0);
        chk("pellets_score", int'(score), 30);
        chk("pellets_high", int'(high_score), 30);
        chk("pellets_new_high", int'(new_high), 1);

        step(GAME_MODE_PLAYING, 0, 1, 0, 0);
        repeat (5) step(GAME_MODE_PLAYING, 0, 0, 1, 0);
        chk("combo_chain", int'(score), 4680);

        step(GAME_MODE_PLAYING, 0, 0, 0, 1);
        step(GAME_MODE_PLAYING, 0, 0, 1, 0);
        step(GAME_MODE_PLAYING, 0, 0, 1, 0);
        chk("cross_score", int'(score), 5280);
        chk("cross_pulse", int'(extra_life), 1);
        step(GAME_MODE_PLAYING, 0, 0, 0, 0);
        chk("pulse_one_cycle", int'(extra_life), 0);

        step(GAME_MODE_PLAYING, 1, 1, 1, 0);
        chk("combined_inc", int'(score), 6140);
        step(GAME_MODE_PLAYING, 0, 0, 1, 0);
        chk("combo_cleared", int'(score), 6340);

        repeat (3) step(GAME_MODE_PLAYING, 0, 0, 1, 0);
        step(GAME_MODE_PLAYING, 0, 0, 0, 1);
        step(GAME_MODE_PLAYING, 0, 0, 1, 0);
        step(GAME_MODE_PLAYING, 0, 0, 1, 0);
        step(GAME_MODE_PLAYING, 0, 1, 0, 0);
        step(GAME_MODE_PLAYING, 0, 0, 1, 0);
        chk("pre_sat", int'(score), 9990);
        step(GAME_MODE_PLAYING, 0, 0, 1, 0);
        chk("sat_ghost", int'(score), 9999);
        step(GAME_MODE_PLAYING, 1, 0, 0, 0);
        chk("sat_hold", int'(score), 9999);
        chk("no_second_pulse", int'(extra_life), 0);

        // game over and new game
        step(GAME_MODE_FAIL, 0, 0, 0, 0);
        step(GAME_MODE_FAIL, 1, 0, 1, 0);
        chk("over_frozen", int'(score), 9999);
        step(GAME_MODE_READY, 1, 0, 0, 0);
        chk("ready_clear", int'(score), 0);
        chk("ready_high_kept", int'(high_score), 9999);
        chk("ready_nh_clear", int'(new_high), 0);
        step(GAME_MODE_READY, 1, 1, 0, 0);
        chk("ready_ignored", int'(score), 0);

        step(GAME_MODE_PLAYING, 1, 0, 0, 0);
        step(GAME_MODE_PLAYING, 0, 1, 0, 0);
        repeat (5) step(GAME_MODE_PLAYING, 0, 0, 1, 0);
        step(GAME_MODE_PLAYING, 0, 0, 0, 1);
        step(GAME_MODE_PLAYING, 0, 1, 0, 0);
        chk("game2_mid", int'(score), 4700);
        step(GAME_MODE_LOADING, 0, 0, 0, 0);
        step(GAME_MODE_LOADING, 1, 0, 0, 0);
        chk("loading_kept", int'(score), 4700);
        step(GAME_MODE_PLAYING, 1, 0, 0, 0);
        step(GAME_MODE_PLAYING, 0, 0, 1, 0);
        chk("resume_ghost", int'(score), 4900);
        repeat (9) step(GAME_MODE_PLAYING, 1, 0, 0, 0);
        chk("pre_life", int'(score), 4990);
        step(GAME_MODE_PLAYING, 1, 0, 0, 0);
        chk("life_at_threshold", int'(extra_life), 1);
        step(GAME_MODE_PLAYING, 1, 0, 0, 0);
        chk("life_once", int'(extra_life), 0);
        chk("game2_no_high", int'(new_high), 0);

        // asynchronous reset mid-game
        rst = 1;
        #1;
        chk("arst_score", int'(score), 0);
        chk("arst_high", int'(high_score), 0);
        chk("arst_new_high", int'(new_high), 0);
        m_state = 0; m_score = 0; m_high = 0; m_nh = 0; m_el = 0; m_combo = 0; m_lg = 0;
        @(negedge clk);
        rst = 0;
        step(GAME_MODE_READY, 0, 0, 0, 0);
        step(GAME_MODE_PLAYING, 0, 0, 0, 0);
        step(GAME_MODE_PLAYING, 1, 0, 0, 0);
        chk("post_rst_high", int'(high_score), 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
